// File: rtl/i2s_source_arbiter_if.sv
//------------------------------------------------------------------------------
// i2s_source_arbiter_if
// Bus between the sample producers / I2S transmitter and the source arbiter.
// master : the arbiter side (drives acks and the granted sample)
// slave  : the producer/transmitter side
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface i2s_source_arbiter_if #(
  parameter int NUM_SRC = 4
);
  logic                   enable;
  logic [NUM_SRC-1:0]     src_valid;
  logic [16*NUM_SRC-1:0]  src_data;
  logic [NUM_SRC-1:0]     src_ack;
  logic [15:0]            sound_out;
  logic                   frame_start;
  logic [2:0]             active_src;
  logic                   grant_valid;
  logic                   underrun;

  modport master (
    input  enable, src_valid, src_data,
    output src_ack, sound_out, frame_start, active_src, grant_valid, underrun
  );

  modport slave (
    output enable, src_valid, src_data,
    input  src_ack, sound_out, frame_start, active_src, grant_valid, underrun
  );
endinterface

`default_nettype wire

// File: rtl/i2s_source_arbiter.sv
//------------------------------------------------------------------------------
// i2s_source_arbiter
// Round-robin selection of one of NUM_SRC sample producers per 32-slot I2S
// frame. Arbitration happens on the edge where frame_cnt == ARB_SLOT; the
// chosen sample is held on sound_out until the transmitter captures it.
// Optional build macro: I2S_ARB_HOLD_LAST_EN (repeat last sample on underrun).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module i2s_source_arbiter #(
  parameter int NUM_SRC  = 4,
  parameter int ARB_SLOT = 29
) (
  input  wire logic             serial_clk,
  input  wire logic             reset,
  i2s_source_arbiter_if.master  bus
);

  // Slot 31 is the transmitter's capture slot, so arbitration there would
  // change sound_out on the very edge it is sampled.
  generate
    if (ARB_SLOT < 0 || ARB_SLOT > 30) begin : g_bad_arb_slot
      $error("i2s_source_arbiter: ARB_SLOT must be in 0..30");
    end
    if (NUM_SRC < 2 || NUM_SRC > 8) begin : g_bad_num_src
      $error("i2s_source_arbiter: NUM_SRC must be in 2..8");
    end
  endgenerate

  localparam logic [4:0] ARB_CNT  = 5'(ARB_SLOT);
  localparam logic [2:0] LAST_RST = 3'(NUM_SRC - 1);

  logic [4:0]         frame_cnt_q,   frame_cnt_d;
  logic [15:0]        sound_out_q,   sound_out_d;
  logic [NUM_SRC-1:0] src_ack_q,     src_ack_d;
  logic               frame_start_q, frame_start_d;
  logic [2:0]         active_src_q,  active_src_d;
  logic               grant_valid_q, grant_valid_d;
  logic               underrun_q,    underrun_d;
  logic [2:0]         last_q,        last_d;

  logic [7:0]         valid_ext;
  logic               found;
  logic [2:0]         win;
  logic [15:0]        win_data;
  int                 idx;

  assign valid_ext = 8'(bus.src_valid);

  // Round-robin search starting just after the last winner, plus data mux.
  always_comb begin
    found    = 1'b0;
    win      = last_q;
    win_data = '0;
    idx      = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!found && valid_ext[idx[2:0]]) begin
        found = 1'b1;
        win   = idx[2:0];
      end
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (win == 3'(i)) win_data = bus.src_data[16*i +: 16];
    end
  end

  // Next-state: free-running frame counter; all grant state changes only on the ARB slot.
  always_comb begin
    frame_cnt_d   = frame_cnt_q + 5'd1;
    frame_start_d = (frame_cnt_q == 5'd31);
    sound_out_d   = sound_out_q;
    src_ack_d     = '0;
    active_src_d  = active_src_q;
    grant_valid_d = grant_valid_q;
    underrun_d    = 1'b0;
    last_d        = last_q;
    if (frame_cnt_q == ARB_CNT) begin
      if (!bus.enable) begin
        sound_out_d   = '0;
        grant_valid_d = 1'b0;
      end else if (found) begin
        sound_out_d   = win_data;
        src_ack_d     = NUM_SRC'(1) << win;
        last_d        = win;
        active_src_d  = win;
        grant_valid_d = 1'b1;
      end else begin
        underrun_d    = 1'b1;
        grant_valid_d = 1'b0;
`ifdef I2S_ARB_HOLD_LAST_EN
        sound_out_d   = sound_out_q;
`else
        sound_out_d   = '0;
`endif
      end
    end
  end

  // State registers; reset parks the counter at 31 to match the transmitter.
  always_ff @(posedge serial_clk or negedge reset) begin
    if (!reset) begin
      frame_cnt_q   <= 5'd31;
      sound_out_q   <= '0;
      src_ack_q     <= '0;
      frame_start_q <= 1'b0;
      active_src_q  <= 3'd0;
      grant_valid_q <= 1'b0;
      underrun_q    <= 1'b0;
      last_q        <= LAST_RST;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      sound_out_q   <= sound_out_d;
      src_ack_q     <= src_ack_d;
      frame_start_q <= frame_start_d;
      active_src_q  <= active_src_d;
      grant_valid_q <= grant_valid_d;
      underrun_q    <= underrun_d;
      last_q        <= last_d;
    end
  end

  assign bus.src_ack     = src_ack_q;
  assign bus.sound_out   = sound_out_q;
  assign bus.frame_start = frame_start_q;
  assign bus.active_src  = active_src_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.underrun    = underrun_q;

endmodule

`default_nettype wire

// File: tb/tb_i2s_source_arbiter.sv
//------------------------------------------------------------------------------
// tb_i2s_source_arbiter
// Directed, table-driven bench for i2s_source_arbiter (NUM_SRC=4, ARB_SLOT=29).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_i2s_source_arbiter;

  logic serial_clk;
  logic reset;

  i2s_source_arbiter_if #(.NUM_SRC(4)) bus ();

  i2s_source_arbiter #(.NUM_SRC(4), .ARB_SLOT(29)) dut (
    .serial_clk (serial_clk),
    .reset      (reset),
    .bus        (bus.master)
  );

  initial serial_clk = 1'b0;
  always #5 serial_clk = ~serial_clk;

  typedef struct {
    logic        en;
    logic [3:0]  valid;
    logic [15:0] d0;
    logic [15:0] exp_out;
    logic [3:0]  exp_ack;
    logic [2:0]  exp_act;
    logic        exp_gv;
    logic        exp_ur;
  } vec_t;

  vec_t        vecs [14];
  int          n_pass;
  int          n_total;
  logic [4:0]  m_cnt;
  logic [15:0] prev_out;
  logic [15:0] ur_out;
  int          nticks;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge serial_clk);
    #1;
    m_cnt = m_cnt + 5'd1;
  endtask

  task automatic drive(input logic en, input logic [3:0] v, input logic [15:0] d0);
    bus.enable    = en;
    bus.src_valid = v;
    bus.src_data  = {16'h4444, 16'h3333, 16'h2222, d0};
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
`ifdef I2S_ARB_HOLD_LAST_EN
    ur_out = 16'h3333;
`else
    ur_out = 16'h0000;
`endif
    //            en valid   d0        out       ack    act   gv  ur
    vecs[0]  = '{1'b1, 4'b1111, 16'h1111, 16'h1111, 4'b0001, 3'd0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 4'b1111, 16'h1111, 16'h2222, 4'b0010, 3'd1, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 4'b1111, 16'h1111, 16'h3333, 4'b0100, 3'd2, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 4'b1111, 16'h1111, 16'h4444, 4'b1000, 3'd3, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 4'b1111, 16'h1111, 16'h1111, 4'b0001, 3'd0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 4'b0100, 16'h1111, 16'h3333, 4'b0100, 3'd2, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 4'b0000, 16'h1111, ur_out,   4'b0000, 3'd2, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 4'b1111, 16'h1111, 16'h0000, 4'b0000, 3'd2, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 4'b1111, 16'h1111, 16'h0000, 4'b0000, 3'd2, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 4'b1111, 16'h1111, 16'h4444, 4'b1000, 3'd3, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 4'b0001, 16'hA5A5, 16'hA5A5, 4'b0001, 3'd0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 4'b1010, 16'h1111, 16'h2222, 4'b0010, 3'd1, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 4'b1010, 16'h1111, 16'h4444, 4'b1000, 3'd3, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 4'b1001, 16'h1111, 16'h1111, 4'b0001, 3'd0, 1'b1, 1'b0};

    // Reset state
    reset = 1'b0;
    drive(1'b1, 4'b1111, 16'h1111);
    repeat (3) @(negedge serial_clk);
    chk("rst_sound_out",   32'(bus.sound_out),   32'h0);
    chk("rst_src_ack",     32'(bus.src_ack),     32'h0);
    chk("rst_frame_start", 32'(bus.frame_start), 32'h0);
    chk("rst_active_src",  32'(bus.active_src),  32'h0);
    chk("rst_grant_valid", 32'(bus.grant_valid), 32'h0);
    chk("rst_underrun",    32'(bus.underrun),    32'h0);

    reset    = 1'b1;
    m_cnt    = 5'd31;
    prev_out = 16'h0000;

    // One vector per frame: check stability before the ARB edge, results after it.
    for (int v = 0; v < 14; v++) begin
      drive(vecs[v].en, vecs[v].valid, vecs[v].d0);
      nticks = 0;
      while (m_cnt != 5'd29 && nticks < 40) begin
        tick();
        nticks++;
        if (m_cnt == 5'd0) chk("frame_start_at_cnt0", 32'(bus.frame_start), 32'h1);
        if (m_cnt == 5'd1) chk("frame_start_cleared", 32'(bus.frame_start), 32'h0);
      end
      if (v == 0) chk("first_arb_latency", 32'(nticks), 32'd30);
      chk("sound_out_stable_pre_arb", 32'(bus.sound_out), 32'(prev_out));
      chk("no_ack_pre_arb", 32'(bus.src_ack), 32'h0);
      tick();
      chk($sformatf("v%0d_sound_out", v),   32'(bus.sound_out),   32'(vecs[v].exp_out));
      chk($sformatf("v%0d_src_ack", v),     32'(bus.src_ack),     32'(vecs[v].exp_ack));
      chk($sformatf("v%0d_active_src", v),  32'(bus.active_src),  32'(vecs[v].exp_act));
      chk($sformatf("v%0d_grant_valid", v), 32'(bus.grant_valid), 32'(vecs[v].exp_gv));
      chk($sformatf("v%0d_underrun", v),    32'(bus.underrun),    32'(vecs[v].exp_ur));
      tick();
      chk($sformatf("v%0d_ack_one_cycle", v), 32'(bus.src_ack),  32'h0);
      chk($sformatf("v%0d_ur_one_cycle", v),  32'(bus.underrun), 32'h0);
      chk($sformatf("v%0d_sound_held", v),    32'(bus.sound_out), 32'(vecs[v].exp_out));
      prev_out = vecs[v].exp_out;
    end

    // Reset while an ack is in flight
    drive(1'b1, 4'b0100, 16'h1111);
    nticks = 0;
    while (m_cnt != 5'd29 && nticks < 40) begin
      tick();
      nticks++;
    end
    tick();
    chk("pre_reset_ack", 32'(bus.src_ack), 32'b0100);
    reset = 1'b0;
    #1;
    chk("async_rst_ack",         32'(bus.src_ack),     32'h0);
    chk("async_rst_sound_out",   32'(bus.sound_out),   32'h0);
    chk("async_rst_grant_valid", 32'(bus.grant_valid), 32'h0);
    chk("async_rst_active_src",  32'(bus.active_src),  32'h0);
    #2;
    reset = 1'b1;
    m_cnt = 5'd31;
    chk("post_rst_frame_start_low", 32'(bus.frame_start), 32'h0);

    // Three frames: frame_start only at cnt==0; the held request re-wins at slot 29.
    for (int i = 0; i < 96; i++) begin
      tick();
      chk("frame_start_phase", 32'(bus.frame_start), (m_cnt == 5'd0) ? 32'h1 : 32'h0);
      chk("held_req_ack",      32'(bus.src_ack),     (m_cnt == 5'd30) ? 32'b0100 : 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/i2s_source_arbiter.md
Name: i2s_source_arbiter

Overview:
- Shares the single I2S transmitter between NUM_SRC audio sample producers.
- Keeps a 32-slot frame counter in lockstep with the transmitter. Once per frame, at a fixed arbitration slot, it picks one requester round-robin and presents that requester's 16-bit sample on sound_out. The transmitter latches sound_out on its frame boundary.
- Sits between the sample producers (filters, tone generators, playback buffers) and the transmitter's sound_in port. Both blocks share serial_clk and reset.

Parameters:
- NUM_SRC, 4, number of requesters (2..8).
- ARB_SLOT, 29, frame-counter value at which arbitration occurs (0..30).

Ports:
- serial_clk  input  1  bit clock, shared with the transmitter
- reset  input  1  asynchronous, active-low
- enable  input  1  arbitration enable, sampled only at the arbitration edge
- src_valid  input  NUM_SRC  per-source sample available; must be held until acked
- src_data  input  16*NUM_SRC  per-source sample; source i occupies bits [16*i+15:16*i]
- src_ack  output  NUM_SRC  one-cycle acknowledge pulse to the winning source
- sound_out  output  16  sample driven to the transmitter's sound_in
- frame_start  output  1  high during the cycle in which frame_cnt==0
- active_src  output  3  index of the most recent winner
- grant_valid  output  1  high while sound_out holds a granted (non-underrun) sample
- underrun  output  1  one-cycle pulse: enabled, but no source valid at arbitration

Behaviour:
- Reset (asynchronous, active-low):
  - frame_cnt=31, sound_out=0, src_ack=0, frame_start=0, active_src=0, grant_valid=0, underrun=0.
  - RR pointer last=NUM_SRC-1, so source 0 has first priority.
  - These values align frame_cnt with the transmitter's reset counter. The transmitter's first capture therefore loads 0.
- Frame counter:
  - frame_cnt (5 bits) increments on every posedge. 31 wraps to 0.
  - The transmitter captures sound_in on the edge where frame_cnt==31.
- frame_start is registered: set on the edge where frame_cnt==31, cleared on the next edge.
- State machine (implicit in frame_cnt):
  - WAIT: frame_cnt!=ARB_SLOT. No changes to sound_out; src_ack=0.
  - ARB: the edge where frame_cnt==ARB_SLOT. Actions:
    - If enable=1 and any src_valid is set: winner w = first set bit searching last+1, last+2, ... modulo NUM_SRC. Then sound_out<=src_data[w], src_ack[w]<=1 for exactly one cycle, last<=w, active_src<=w, grant_valid<=1, underrun<=0.
    - If enable=1 and no src_valid is set: underrun<=1 for one cycle, grant_valid<=0, sound_out<=0 (see Optional Feature).
    - If enable=0: sound_out<=0, grant_valid<=0, no ack, no underrun, last unchanged.
- sound_out is stable from the ARB edge through the following frame_cnt==31 edge. The transmitter never samples a changing value.
- Handshake: a transfer occurs only at the ARB edge. The source sees src_ack the following cycle and may then change valid/data. Changes to valid/data at other times are ignored.
- Latency:
  - Sample accepted at the ARB edge (cnt=ARB_SLOT) -> captured by the transmitter (31-ARB_SLOT) edges later.
  - Serialised starting at the next frame: MSB appears on sound_bit_out 2 edges after the capture edge.
- Round-robin:
  - Only the winner advances the pointer.
  - A single persistent requester wins every frame.
  - With all NUM_SRC valid, each source wins once every NUM_SRC frames.
- At most one src_ack bit is high at any time.
- Out-of-range ARB_SLOT (31) is illegal. Elaboration emits an error.
- Reset mid-frame:
  - All outputs return to their reset values immediately, including cancelling any in-flight src_ack.
  - Counter realigns to 31.
  - A source whose ack was cancelled has not transferred; it keeps valid asserted.

Optional Feature:
- Macro I2S_ARB_HOLD_LAST_EN.
- Defined: on underrun, sound_out keeps its previous value (repeat last sample). Disabled frames still output 0.
- Undefined: on underrun, sound_out<=0.
- underrun pulse and grant_valid=0 behave identically in both builds.

Test Plan:
- Reset release, enable=1, src_valid=0001, src0=0xA5A5 -> first ARB edge (cnt=29): sound_out=0xA5A5, src_ack=0001 for 1 cycle, active_src=0. Transmitter serialises 0xA5A5 in the frame after its cnt==31 capture.
- src_valid=1111 held, data 0x1111/0x2222/0x3333/0x4444 -> successive frames output 0x1111, 0x2222, 0x3333, 0x4444, 0x1111. Each ack is one-hot.
- Winner src2 granted, then src_valid=0000 at the next ARB edge:
  - Default build: underrun=1 for 1 cycle, sound_out=0, grant_valid=0.
  - With I2S_ARB_HOLD_LAST_EN: sound_out stays 0x3333.
- enable=0 with src_valid=1111 -> sound_out=0, src_ack=0, underrun=0 for all frames. Re-enable -> next grant goes to (last+1).
- Assert reset on the cycle src_ack=0100 is high -> src_ack=0 and sound_out=0 immediately. After release, frame_cnt=31 and frame_start pulses one edge later.
- frame_start check over 3 frames -> one pulse every 32 cycles, coincident with the transmitter's bit_counter==0.
